mem_stage: RTL and testbench

- Memory-access stage of the 32-bit LoongArch pipeline, directly downstream of the execute stage.
- Inputs come from the EX/MEM pipeline register: the ALU result, the effective address, store data and a decoded memory-op code.
- For loads and stores it runs a request/acknowledge transaction with the data SRAM bridge, stalling upstream until the transaction completes.
- Produces a registered writeback bundle for the WB stage, with load results sign/zero-extended and an address-misalignment flag.

---
 rtl/mem_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, runs one req/ack SRAM transaction per load/store.
// Latency: 1 edge for non-memory ops, 3 edges plus ack wait for memory ops; stalls upstream while busy.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        mem_op_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [DATA_W-1:0] inst_pc_i,
    input  logic [1:0]        excepttype_i,
    output logic              stallreq,
    output logic              data_req,
    output logic              data_we,
    output logic [DATA_W-1:0] data_addr,
    output logic [STRB_W-1:0] data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_ack,
    output logic              out_valid,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] inst_pc_o,
    output logic [1:0]        excepttype_o,
    output logic              ale_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              state_q, state_d;
    logic                flushed_q, flushed_d;
    logic [4:0]          b_wd_q, b_wd_d;
    logic                b_wreg_q, b_wreg_d;
    logic [DATA_W-1:0]   b_pc_q, b_pc_d;
    logic [1:0]          b_exc_q, b_exc_d;
    logic [3:0]          b_op_q, b_op_d;
    logic [1:0]          b_off_q, b_off_d;
    logic [DATA_W-1:0]   b_res_q, b_res_d;

    logic                out_valid_d, wreg_d, ale_d;
    logic [4:0]          wd_d;
    logic [DATA_W-1:0]   wdata_d, inst_pc_d;
    logic [1:0]          exc_d;
    logic                data_req_d, data_we_d;
    logic [DATA_W-1:0]   data_addr_d, data_wdata_d;
    logic [STRB_W-1:0]   data_wstrb_d;

    logic       is_load, is_store, is_mem, is_half, is_word, misal, mem_ok;
    logic [1:0] off;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    assign off      = mem_addr_i[1:0];
    assign is_load  = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd5);
    assign is_store = (mem_op_i >= 4'd6) && (mem_op_i <= 4'd8);
    assign is_mem   = (is_load || is_store) && (excepttype_i == 2'b00);
    assign is_half  = (mem_op_i == 4'd2) || (mem_op_i == 4'd5) || (mem_op_i == 4'd7);
    assign is_word  = (mem_op_i == 4'd3) || (mem_op_i == 4'd8);
    assign misal    = is_mem && ((is_half && off[0]) || (is_word && (off != 2'b00)));
    assign mem_ok   = in_valid && !flush && is_mem && !misal;

    assign stallreq = (state_q == REQ) || ((state_q == IDLE) && mem_ok);

    always_comb begin
        ld_byte = data_rdata[7:0];
        case (b_off_q)
            2'd1:    ld_byte = data_rdata[15:8];
            2'd2:    ld_byte = data_rdata[23:16];
            2'd3:    ld_byte = data_rdata[31:24];
            default: ld_byte = data_rdata[7:0];
        endcase
        ld_half = b_off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    end

    always_comb begin
        state_d      = state_q;
        flushed_d    = flushed_q;
        b_wd_d       = b_wd_q;
        b_wreg_d     = b_wreg_q;
        b_pc_d       = b_pc_q;
        b_exc_d      = b_exc_q;
        b_op_d       = b_op_q;
        b_off_d      = b_off_q;
        b_res_d      = b_res_q;
        out_valid_d  = 1'b0;
        wreg_d       = 1'b0;
        ale_d        = ale_o;
        wd_d         = wd_o;
        wdata_d      = wdata_o;
        inst_pc_d    = inst_pc_o;
        exc_d        = excepttype_o;
        data_req_d   = data_req;
        data_we_d    = data_we;
        data_addr_d  = data_addr;
        data_wstrb_d = data_wstrb;
        data_wdata_d = data_wdata;

        case (state_q)
            IDLE: begin
                if (!in_valid || flush) begin
                    state_d = IDLE;
                end else if (mem_ok) begin
                    state_d      = REQ;
                    flushed_d    = 1'b0;
                    b_wd_d       = wd_i;
                    b_wreg_d     = wreg_i;
                    b_pc_d       = inst_pc_i;
                    b_exc_d      = excepttype_i;
                    b_op_d       = mem_op_i;
                    b_off_d      = off;
                    data_req_d   = 1'b1;
                    data_we_d    = is_store;
                    data_addr_d  = {mem_addr_i[DATA_W-1:2], 2'b00};
                    data_wstrb_d = 4'b0000;
                    data_wdata_d = reg2_i;
                    case (mem_op_i)
                        4'd6: begin
                            data_wstrb_d = 4'b0001 << off;
                            data_wdata_d = {4{reg2_i[7:0]}};
                        end
                        4'd7: begin
                            data_wstrb_d = 4'b0011 << off;
                            data_wdata_d = {2{reg2_i[15:0]}};
                        end
                        4'd8:    data_wstrb_d = 4'b1111;
                        default: data_wstrb_d = 4'b0000;
                    endcase
                end else begin
                    out_valid_d = 1'b1;
                    wd_d        = wd_i;
                    wreg_d      = wreg_i && !misal;
                    wdata_d     = wdata_i;
                    inst_pc_d   = inst_pc_i;
                    exc_d       = excepttype_i;
                    ale_d       = misal;
                end
            end
            REQ: begin
                // A flush here cannot abort the bus transaction; it only suppresses the result.
                if (flush) flushed_d = 1'b1;
                if (data_ack) begin
                    data_req_d = 1'b0;
                    flushed_d  = 1'b0;
                    state_d    = (flushed_q || flush) ? IDLE : DONE;
                    case (b_op_q)
                        4'd1:    b_res_d = {{24{ld_byte[7]}}, ld_byte};
                        4'd2:    b_res_d = {{16{ld_half[15]}}, ld_half};
                        4'd3:    b_res_d = data_rdata;
                        4'd4:    b_res_d = {24'd0, ld_byte};
                        4'd5:    b_res_d = {16'd0, ld_half};
                        default: b_res_d = '0;
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    out_valid_d = 1'b1;
                    wd_d        = b_wd_q;
                    wreg_d      = b_wreg_q;
                    wdata_d     = b_res_q;
                    inst_pc_d   = b_pc_q;
                    exc_d       = b_exc_q;
                    ale_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            flushed_q    <= 1'b0;
            b_wd_q       <= '0;
            b_wreg_q     <= 1'b0;
            b_pc_q       <= '0;
            b_exc_q      <= '0;
            b_op_q       <= '0;
            b_off_q      <= '0;
            b_res_q      <= '0;
            out_valid    <= 1'b0;
            wd_o         <= '0;
            wreg_o       <= 1'b0;
            wdata_o      <= '0;
            inst_pc_o    <= '0;
            excepttype_o <= '0;
            ale_o        <= 1'b0;
            data_req     <= 1'b0;
            data_we      <= 1'b0;
            data_addr    <= '0;
            data_wstrb   <= '0;
            data_wdata   <= '0;
        end else begin
            state_q      <= state_d;
            flushed_q    <= flushed_d;
            b_wd_q       <= b_wd_d;
            b_wreg_q     <= b_wreg_d;
            b_pc_q       <= b_pc_d;
            b_exc_q      <= b_exc_d;
            b_op_q       <= b_op_d;
            b_off_q      <= b_off_d;
            b_res_q      <= b_res_d;
            out_valid    <= out_valid_d;
            wd_o         <= wd_d;
            wreg_o       <= wreg_d;
            wdata_o      <= wdata_d;
            inst_pc_o    <= inst_pc_d;
            excepttype_o <= exc_d;
            ale_o        <= ale_d;
            data_req     <= data_req_d;
            data_we      <= data_we_d;
            data_addr    <= data_addr_d;
            data_wstrb   <= data_wstrb_d;
            data_wdata   <= data_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU passthrough, loads/stores with ack waits, misalignment, flush, reset.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, wreg_i, data_ack;
    logic [4:0]  wd_i;
    logic [3:0]  mem_op_i;
    logic [31:0] wdata_i, mem_addr_i, reg2_i, inst_pc_i, data_rdata;
    logic [1:0]  excepttype_i;
    logic        stallreq, data_req, data_we, out_valid, wreg_o, ale_o;
    logic [31:0] data_addr, data_wdata, wdata_o, inst_pc_o;
    logic [3:0]  data_wstrb;
    logic [4:0]  wd_o;
    logic [1:0]  excepttype_o;

    int passes = 0;
    int total  = 0;

    // values captured during a memory transaction
    logic        r_req, r_we, r_done_stall;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_strb;
    int          r_stalls;

    mem_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_op_i(mem_op_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .inst_pc_i(inst_pc_i),
        .excepttype_i(excepttype_i), .stallreq(stallreq), .data_req(data_req),
        .data_we(data_we), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
        .out_valid(out_valid), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .inst_pc_o(inst_pc_o), .excepttype_o(excepttype_o), .ale_o(ale_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [4:0] wd, input logic [31:0] wdat, input logic wr);
        in_valid = 1'b1; mem_op_i = op; mem_addr_i = addr; reg2_i = r2;
        wd_i = wd; wdata_i = wdat; wreg_i = wr; inst_pc_i = 32'h1c00_0000 + addr;
        excepttype_i = 2'b00;
    endtask

    // Full transaction: the ack arrives after `waits` idle REQ cycles; ends one edge after DONE.
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r2,
                           input logic [31:0] rdata, input int waits);
        r_stalls = 0;
        drive(op, addr, r2, 5'd7, 32'hDEAD_0000, (op <= 4'd5));
        #1;
        if (stallreq) r_stalls++;
        tick();
        r_req = data_req; r_we = data_we; r_addr = data_addr;
        r_strb = data_wstrb; r_wdata = data_wdata;
        for (int i = 0; i < waits; i++) begin
            if (stallreq) r_stalls++;
            tick();
        end
        data_ack = 1'b1; data_rdata = rdata;
        if (stallreq) r_stalls++;
        tick();
        data_ack = 1'b0; data_rdata = 32'h0; in_valid = 1'b0; mem_op_i = 4'd0;
        #1;
        r_done_stall = stallreq;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wreg_i = 1'b0; data_ack = 1'b0;
        wd_i = '0; mem_op_i = '0; wdata_i = '0; mem_addr_i = '0; reg2_i = '0;
        inst_pc_i = '0; data_rdata = '0; excepttype_i = '0;
        tick(); tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data_req", {31'd0, data_req}, 32'd0);
        check("rst_wdata_o", wdata_o, 32'd0);
        check("rst_stallreq", {31'd0, stallreq}, 32'd0);
        rst = 1'b0;

        // ALU passthrough
        drive(4'd0, 32'h0, 32'h0, 5'd5, 32'h0000_1234, 1'b1);
        #1;
        check("alu_stall", {31'd0, stallreq}, 32'd0);
        tick();
        check("alu_valid", {31'd0, out_valid}, 32'd1);
        check("alu_wd", {27'd0, wd_o}, 32'd5);
        check("alu_wdata", wdata_o, 32'h0000_1234);
        check("alu_wreg", {31'd0, wreg_o}, 32'd1);
        check("alu_req", {31'd0, data_req}, 32'd0);
        in_valid = 1'b0;
        tick();
        check("bubble_valid", {31'd0, out_valid}, 32'd0);

        // LD.B sign-extend, ack two cycles after request rises
        run_mem(4'd1, 32'h0000_1002, 32'h0, 32'h80FF_7F00, 2);
        check("ldb_req", {31'd0, r_req}, 32'd1);
        check("ldb_we", {31'd0, r_we}, 32'd0);
        check("ldb_addr", r_addr, 32'h0000_1000);
        check("ldb_strb", {28'd0, r_strb}, 32'd0);
        check("ldb_stalls", r_stalls, 32'd4);
        check("ldb_done_stall", {31'd0, r_done_stall}, 32'd0);
        check("ldb_valid", {31'd0, out_valid}, 32'd1);
        check("ldb_data", wdata_o, 32'hFFFF_FFFF);
        check("ldb_wd", {27'd0, wd_o}, 32'd7);
        check("ldb_pc", inst_pc_o, 32'h1c00_1002);
        check("ldb_req_after", {31'd0, data_req}, 32'd0);

        run_mem(4'd4, 32'h0000_1002, 32'h0, 32'h80FF_7F00, 2);
        check("ldbu_data", wdata_o, 32'h0000_00FF);
        run_mem(4'd2, 32'h0000_1002, 32'h0, 32'h80FF_7F00, 0);
        check("ldh_data", wdata_o, 32'hFFFF_80FF);
        check("ldh_stalls", r_stalls, 32'd2);
        run_mem(4'd5, 32'h0000_1000, 32'h0, 32'h80FF_7F00, 1);
        check("ldhu_data", wdata_o, 32'h0000_7F00);
        run_mem(4'd3, 32'h0000_1004, 32'h0, 32'h1357_9BDF, 0);
        check("ldw_data", wdata_o, 32'h1357_9BDF);

        // stores
        run_mem(4'd7, 32'h0000_2002, 32'hAABB_CCDD, 32'h0, 0);
        check("sth_we", {31'd0, r_we}, 32'd1);
        check("sth_strb", {28'd0, r_strb}, 32'h0000_000C);
        check("sth_wdata", r_wdata, 32'hCCDD_CCDD);
        check("sth_valid", {31'd0, out_valid}, 32'd1);
        check("sth_wdata_o", wdata_o, 32'd0);
        check("sth_wreg_o", {31'd0, wreg_o}, 32'd0);
        run_mem(4'd6, 32'h0000_2001, 32'hAABB_CCDD, 32'h0, 0);
        check("stb_strb", {28'd0, r_strb}, 32'h0000_0002);
        check("stb_wdata", r_wdata, 32'hDDDD_DDDD);
        run_mem(4'd8, 32'h0000_2000, 32'hAABB_CCDD, 32'h0, 0);
        check("stw_strb", {28'd0, r_strb}, 32'h0000_000F);
        check("stw_wdata", r_wdata, 32'hAABB_CCDD);

        // misaligned LD.W
        drive(4'd3, 32'h0000_3001, 32'h0, 5'd3, 32'h0, 1'b1);
        #1;
        check("ale_stall", {31'd0, stallreq}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("ale_req", {31'd0, data_req}, 32'd0);
        check("ale_flag", {31'd0, ale_o}, 32'd1);
        check("ale_wreg", {31'd0, wreg_o}, 32'd0);
        check("ale_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("ale_req_later", {31'd0, data_req}, 32'd0);

        // exception bits suppress the memory access and pass through
        drive(4'd3, 32'h0000_3000, 32'h0, 5'd4, 32'h0000_0055, 1'b1);
        excepttype_i = 2'b10;
        #1;
        check("exc_stall", {31'd0, stallreq}, 32'd0);
        tick();
        in_valid = 1'b0; excepttype_i = 2'b00;
        check("exc_req", {31'd0, data_req}, 32'd0);
        check("exc_pass", {30'd0, excepttype_o}, 32'd2);
        check("exc_valid", {31'd0, out_valid}, 32'd1);

        // flush while in REQ: transaction completes, result dropped
        drive(4'd3, 32'h0000_4000, 32'h0, 5'd8, 32'h0, 1'b1);
        tick();
        flush = 1'b1;
        check("fl_req", {31'd0, data_req}, 32'd1);
        tick();
        flush = 1'b0;
        tick(); tick();
        check("fl_req_held", {31'd0, data_req}, 32'd1);
        check("fl_stall_held", {31'd0, stallreq}, 32'd1);
        check("fl_addr_held", data_addr, 32'h0000_4000);
        data_ack = 1'b1; data_rdata = 32'h1111_2222;
        tick();
        data_ack = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_req_drop", {31'd0, data_req}, 32'd0);
        check("fl_stall_drop", {31'd0, stallreq}, 32'd0);
        check("fl_no_out", {31'd0, out_valid}, 32'd0);
        tick();
        check("fl_no_out2", {31'd0, out_valid}, 32'd0);
        drive(4'd0, 32'h0, 32'h0, 5'd9, 32'h0000_BEEF, 1'b1);
        tick();
        in_valid = 1'b0;
        check("fl_next_valid", {31'd0, out_valid}, 32'd1);
        check("fl_next_data", wdata_o, 32'h0000_BEEF);
        check("fl_next_wd", {27'd0, wd_o}, 32'd9);

        // reset during the wait
        drive(4'd3, 32'h0000_5000, 32'h0, 5'd2, 32'h0, 1'b1);
        tick();
        check("rr_req", {31'd0, data_req}, 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rr_req_clr", {31'd0, data_req}, 32'd0);
        check("rr_valid", {31'd0, out_valid}, 32'd0);
        check("rr_stall", {31'd0, stallreq}, 32'd0);
        check("rr_addr", data_addr, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
